// File: rtl/ahb_apb_bridge.sv
// AHB-Lite to APB bridge: one outstanding word transfer, up to four APB slaves, two-cycle ERROR response.
// Optional APB_TIMEOUT_EN: abort an ACCESS phase after 15 cycles without PREADY.
module ahb_apb_bridge (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [31:0] PADDR,
    output logic [3:0]  PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t      state;
    logic [31:0] pwdata_q;
    logic        can_accept;
    logic        accept;
    logic        decode_ok;
    logic [3:0]  sel_dec;

`ifdef APB_TIMEOUT_EN
    logic [3:0]  tmo_cnt;
`endif

    // A new address phase may only land while the bridge is showing HREADYOUT=1.
    assign can_accept = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];
    assign decode_ok  = (HADDR[15:14] == 2'b00) && (HSIZE == 2'b10);
    assign sel_dec    = 4'b0001 << HADDR[13:12];

    // Write data arrives in the AHB data phase, which coincides with SETUP.
    assign PWDATA = (state == ST_SETUP && PWRITE) ? HWDATA : pwdata_q;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PADDR     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (accept && decode_ok) begin
                        state     <= ST_SETUP;
                        PADDR     <= HADDR;
                        PWRITE    <= HWRITE;
                        PSEL      <= sel_dec;
                        PENABLE   <= 1'b0;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b0;
                    end else if (accept) begin
                        state     <= ST_ERR1;
                        PSEL      <= '0;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                    if (PWRITE) begin
                        pwdata_q <= HWDATA;
                    end
`ifdef APB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (PSLVERR) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                            if (!PWRITE) begin
                                HRDATA <= PRDATA;
                            end
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        // The 15th stalled ACCESS cycle drives the count to 15 and aborts.
                        tmo_cnt <= tmo_cnt + 4'd1;
                        if (tmo_cnt == 4'd14) begin
                            state     <= ST_ERR1;
                            PSEL      <= '0;
                            PENABLE   <= 1'b0;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end
                    end
`endif
                end

                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= '0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ahb_apb_bridge.md
AHB_APB_BRIDGE -- requirements
Module: ahb_apb_bridge

Interface
REQ-001 HCLK  in  1  sole clock; all state changes on rising edge.
REQ-002 HRESETn  in  1  reset, synchronous, active-low.
REQ-003 HSEL  in  1  bridge selected by AHB decoder.
REQ-004 HADDR  in  32  AHB address-phase address.
REQ-005 HWRITE  in  1  1=write, 0=read.
REQ-006 HSIZE  in  2  transfer size; only 2'b10 (word) supported.
REQ-007 HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 HWDATA  in  32  AHB write data, valid in data phase.
REQ-009 HREADY  in  1  bus-level ready; address phase sampled only when 1.
REQ-010 HREADYOUT  out  1  bridge ready; 0 inserts wait states.
REQ-011 HRESP  out  1  0=OKAY, 1=ERROR.
REQ-012 HRDATA  out  32  read data, registered.
REQ-013 PADDR  out  32  APB address, registered.
REQ-014 PSEL  out  4  one-hot APB slave select.
REQ-015 PENABLE  out  1  APB access phase.
REQ-016 PWRITE  out  1  APB direction.
REQ-017 PWDATA  out  32  APB write data.
REQ-018 PRDATA  in  32  read data from APB slave mux.
REQ-019 PREADY  in  1  APB slave ready.
REQ-020 PSLVERR  in  1  APB slave error.

Function
REQ-021 Transfer accepted when HSEL & HREADY & HTRANS[1] in state IDLE or DONE; HADDR/HWRITE/HSIZE registered.
REQ-022 HSEL with HTRANS IDLE/BUSY: no APB activity, HREADYOUT=1, HRESP=0.
REQ-023 FSM states: IDLE, SETUP, ACCESS, DONE, ERR1, ERR2.
REQ-024 Decode: HADDR[15:12]=0..3 selects PSEL bit n; any other value, or HSIZE!=2'b10, is a decode error.
REQ-025 Accepted, decode ok -> SETUP next cycle: PSEL one-hot, PENABLE=0, HREADYOUT=0, PWDATA=HWDATA passed combinationally (write).
REQ-026 SETUP -> ACCESS unconditionally; PENABLE=1, PSEL/PADDR/PWRITE held, PWDATA held from register captured at end of SETUP.
REQ-027 ACCESS & !PREADY: stay, HREADYOUT=0.
REQ-028 ACCESS & PREADY & !PSLVERR -> DONE; PRDATA captured into HRDATA (reads only); PSEL/PENABLE cleared.
REQ-029 DONE: HREADYOUT=1, HRESP=0; new accepted transfer -> SETUP, else IDLE.
REQ-030 ACCESS & PREADY & PSLVERR, or decode error -> ERR1; no PSEL asserted on decode error.
REQ-031 ERR1: HREADYOUT=0, HRESP=1 -> ERR2: HREADYOUT=1, HRESP=1 -> IDLE; ERR2 accepts a new transfer like DONE.
REQ-032 Minimum latency: address phase T0, SETUP T1, ACCESS T2, HREADYOUT=1 T3; each APB wait adds one cycle.
REQ-033 HRDATA unchanged on writes and errors.

Reset
REQ-034 HRESETn=0 at a clock edge: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0, timeout counter=0.
REQ-035 Reset mid-transfer aborts immediately; the transfer is not retried.

Configuration
REQ-036 APB_TIMEOUT_EN defined: 4-bit counter cleared on SETUP, increments each ACCESS cycle with PREADY=0; at 15, PSEL/PENABLE cleared -> ERR1.
REQ-037 APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for PREADY.

Verification
REQ-038 Write HADDR=0x0000_1004, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL=4'b0010 T1-T2, PENABLE T2, PWDATA=0xDEADBEEF, HREADYOUT=1 T3, HRESP=0.
REQ-039 Read HADDR=0x0000_3000, PREADY low 2 cycles, PRDATA=0x12345678 -> HREADYOUT=0 T1-T4, HRDATA=0x12345678 with HREADYOUT=1 at T5.
REQ-040 Read HADDR=0x0000_5000 -> PSEL stays 0; ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (HREADYOUT=1,HRESP=1).
REQ-041 Write with PSLVERR=1, PREADY=1 in ACCESS -> two-cycle ERROR response; HRDATA unchanged.
REQ-042 Back-to-back writes to 0x0000_0000 and 0x0000_2000, second address phase in DONE -> second SETUP immediately follows DONE.
REQ-043 APB_TIMEOUT_EN, PREADY held 0 -> PSEL dropped after 15 ACCESS cycles, ERROR response; HRESETn=0 during ACCESS -> all outputs at reset values next edge.
